// File: rtl/debug_loader.sv
`default_nettype none
// ============================================================================
//  Module      : debug_loader
//  Description : Byte-stream program loader. Parses CMD/ADDR/LEN frames from
//                a UART RX byte source and drives the core's debug write
//                port into imem/dmem, holding the core in reset while loading.
//  Revision    : 1.0  initial release
// ============================================================================
module debug_loader #(
    parameter int          AddrWidth     = 12,
    parameter int          TimeoutCycles = 100000,
    parameter bit          StartHalted   = 1'b1,
    parameter logic [7:0]  CmdImem       = 8'hA5,
    parameter logic [7:0]  CmdDmem       = 8'h5A,
    parameter logic [7:0]  CmdRun        = 8'h0F
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data_i,
    input  logic                 rx_valid_i,
    output logic                 rx_ready_o,
    output logic                 dbg_imem_o,
    output logic                 dbg_dmem_o,
    output logic [AddrWidth-1:0] dbg_addr_o,
    output logic [7:0]           dbg_data_o,
    output logic                 core_reset_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    typedef enum logic [2:0] {
        S_RUN  = 3'd0,
        S_IDLE = 3'd1,
        S_A_LO = 3'd2,
        S_A_HI = 3'd3,
        S_L_LO = 3'd4,
        S_L_HI = 3'd5,
        S_DATA = 3'd6
    } state_e;

    localparam state_e C_RESET_STATE = StartHalted ? S_IDLE : S_RUN;

    // Idle-cycle counter only needs to reach TimeoutCycles-1 before aborting.
    localparam int             C_TMO_W    = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(TimeoutCycles - 1);
    localparam logic [C_TMO_W-1:0] C_TMO_ONE  = C_TMO_W'(1);

    state_e               state_q;
    logic                 tgt_dmem_q;      // 1: frame targets dmem, 0: imem
    logic [15:0]          addr_q;          // full frame address; low bits drive the port
    logic [15:0]          len_q;
    logic [C_TMO_W-1:0]   tmo_q;
    logic                 dbg_imem_q;
    logic                 dbg_dmem_q;
    logic [AddrWidth-1:0] dbg_addr_q;
    logic [7:0]           dbg_data_q;
    logic                 core_reset_q;
    logic                 done_q;
    logic                 err_q;

    logic                 rx_fire;
    logic                 in_frame;
    logic [15:0]          frame_len_d;
    logic                 is_load_cmd;

    assign rx_ready_o   = 1'b1;
    assign rx_fire      = rx_valid_i;
    assign in_frame     = (state_q != S_IDLE) && (state_q != S_RUN);
    assign frame_len_d  = {rx_data_i, len_q[7:0]};
    assign is_load_cmd  = (rx_data_i == CmdImem) || (rx_data_i == CmdDmem);

    // Frame parser, timeout watchdog and registered debug-port outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= C_RESET_STATE;
            tgt_dmem_q   <= 1'b0;
            addr_q       <= 16'd0;
            len_q        <= 16'd0;
            tmo_q        <= '0;
            dbg_imem_q   <= 1'b0;
            dbg_dmem_q   <= 1'b0;
            dbg_addr_q   <= '0;
            dbg_data_q   <= 8'd0;
            core_reset_q <= StartHalted;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            dbg_imem_q <= 1'b0;
            dbg_dmem_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;

            // Watchdog: counts idle cycles inside a frame; any accepted byte clears it.
            if (in_frame && !rx_fire) begin
                if (tmo_q == C_TMO_LAST) begin
                    state_q <= S_IDLE;
                    err_q   <= 1'b1;
                    tmo_q   <= '0;
                end else begin
                    tmo_q <= tmo_q + C_TMO_ONE;
                end
            end else begin
                tmo_q <= '0;
            end

            if (rx_fire) begin
                case (state_q)
                    S_RUN: begin
                        // Non-load bytes are silently ignored while the core runs.
                        if (is_load_cmd) begin
                            tgt_dmem_q   <= (rx_data_i == CmdDmem);
                            state_q      <= S_A_LO;
                            core_reset_q <= 1'b1;
                        end
                    end
                    S_IDLE: begin
                        if (is_load_cmd) begin
                            tgt_dmem_q <= (rx_data_i == CmdDmem);
                            state_q    <= S_A_LO;
                        end else if (rx_data_i == CmdRun) begin
                            state_q      <= S_RUN;
                            core_reset_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    S_A_LO: begin
                        addr_q[7:0] <= rx_data_i;
                        state_q     <= S_A_HI;
                    end
                    S_A_HI: begin
                        addr_q[15:8] <= rx_data_i;
                        state_q      <= S_L_LO;
                    end
                    S_L_LO: begin
                        len_q[7:0] <= rx_data_i;
                        state_q    <= S_L_HI;
                    end
                    S_L_HI: begin
                        len_q <= frame_len_d;
                        if (frame_len_d == 16'd0) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        // Every byte here is payload, including ones that look like commands.
                        dbg_imem_q <= ~tgt_dmem_q;
                        dbg_dmem_q <= tgt_dmem_q;
                        dbg_addr_q <= addr_q[AddrWidth-1:0];
                        dbg_data_q <= rx_data_i;
                        addr_q     <= addr_q + 16'd1;
                        len_q      <= len_q - 16'd1;
                        if (len_q == 16'd1) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign dbg_imem_o   = dbg_imem_q;
    assign dbg_dmem_o   = dbg_dmem_q;
    assign dbg_addr_o   = dbg_addr_q;
    assign dbg_data_o   = dbg_data_q;
    assign core_reset_o = core_reset_q;
    assign busy_o       = in_frame;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule
`default_nettype wire
